arrow_scheduler: RTL and testbench

- Sequences the falling-arrow datapath: owns the 20 arrow slots, spawns arrows from a pattern source on a beat grid, and advances every active arrow once per game tick.
- Releases a slot when the arrow is hit or leaves the screen.
- Sits between the pattern source and the game logic/drawing path, clocked by the slow game tick.
- Exports per-slot active/direction/y for rendering and hit judging.

---
 rtl/arrow_pkg.sv | 23 ++
 rtl/arrow_scheduler_slot_alloc.sv | 27 ++
 rtl/arrow_scheduler.sv | 147 ++++++++++++++
 tb/tb_arrow_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// Shared types and defaults for the arrow scheduler: direction codes,
// sequencer states and slot-count constants.
package arrow_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FETCH = 2'd2,
    ST_ALLOC = 2'd3
  } state_e;

  localparam int DEF_NUM_SLOTS = 20;
  localparam int DEF_Y_W       = 10;
  localparam int SLOT_IDX_W    = 5;

endpackage

// File: rtl/arrow_scheduler_slot_alloc.sv
// Lowest-index free slot finder: purely combinational priority encoder
// over the slot occupancy vector.
module slot_alloc
  import arrow_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
  input  logic [NUM_SLOTS-1:0]  active,
  output logic [SLOT_IDX_W-1:0] idx,
  output logic                  found
);

  // NOTE: outputs get defaults before the loop so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan downwards so the last hit, the lowest free index, wins.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        idx   = SLOT_IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arrow_scheduler.sv
// Arrow slot sequencer: spawns arrows from the pattern stream on a beat grid,
// moves active arrows each game tick and frees slots on hit or exit.
module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int Y_W        = DEF_Y_W,
  parameter int BEAT_TICKS = 32,
  parameter int STEP       = 2,
  parameter int SPAWN_Y    = 0,
  parameter int EXIT_Y     = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     pat_valid,
  input  logic                     pat_rest,
  input  logic [1:0]               pat_dir,
  output logic                     pat_ready,
  input  logic                     hit_valid,
  input  logic [4:0]               hit_slot,
  output logic [NUM_SLOTS-1:0]     slot_active,
  output logic [2*NUM_SLOTS-1:0]   slot_dir,
  output logic [Y_W*NUM_SLOTS-1:0] slot_y,
  output logic                     spawn_pulse,
  output logic                     miss_pulse,
  output logic                     overflow_pulse,
  output logic                     beat_slip
);

  localparam int CNT_W = $clog2(BEAT_TICKS);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q;
  logic                    tc, accept, do_alloc;
  logic                    lat_rest_q;
  dir_e                    lat_dir_q;

  logic [NUM_SLOTS-1:0]    active_q;
  logic [1:0]              dir_q [NUM_SLOTS];
  logic [Y_W-1:0]          y_q   [NUM_SLOTS];
  logic [Y_W:0]            y_inc [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    hit_vec, exit_vec;
  logic [SLOT_IDX_W-1:0]   free_idx;
  logic                    free_found;

  assign tc       = (beat_cnt_q == CNT_W'(BEAT_TICKS - 1));
  // pat_ready is cleared while paused, so the first cycle after a resume in
  // FETCH cannot accept; the handshake only completes on a visible ready.
  assign accept   = (state_q == ST_FETCH) && pat_ready && pat_valid;
  assign do_alloc = (state_q == ST_ALLOC) && !lat_rest_q;

  slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
    .active (active_q),
    .idx    (free_idx),
    .found  (free_found)
  );

  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_WAIT;
        ST_WAIT:  if (tc) state_d = ST_FETCH;
        ST_FETCH: if (accept) state_d = ST_ALLOC;
        ST_ALLOC: state_d = ST_WAIT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Exit is judged one bit wider than y so the sum cannot wrap below EXIT_Y.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      y_inc[i]    = {1'b0, y_q[i]} + (Y_W + 1)'(STEP);
      hit_vec[i]  = hit_valid && active_q[i] && (hit_slot == SLOT_IDX_W'(i));
      exit_vec[i] = active_q[i] && (y_inc[i] >= (Y_W + 1)'(EXIT_Y));
    end
  end

  // NOTE: all state here uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      beat_cnt_q     <= '0;
      pat_ready      <= 1'b0;
      lat_rest_q     <= 1'b0;
      lat_dir_q      <= DIR_UP;
      spawn_pulse    <= 1'b0;
      miss_pulse     <= 1'b0;
      overflow_pulse <= 1'b0;
      beat_slip      <= 1'b0;
    end else if (enable) begin
      state_q        <= state_d;
      beat_cnt_q     <= tc ? '0 : beat_cnt_q + CNT_W'(1);
      pat_ready      <= (state_d == ST_FETCH);
      if (accept) begin
        lat_rest_q <= pat_rest;
        lat_dir_q  <= dir_e'(pat_dir);
      end
      spawn_pulse    <= do_alloc && free_found;
      overflow_pulse <= do_alloc && !free_found;
      miss_pulse     <= |(exit_vec & ~hit_vec);
      beat_slip      <= (state_q == ST_FETCH) && tc && !accept;
    end else begin
      pat_ready      <= 1'b0;
      spawn_pulse    <= 1'b0;
      miss_pulse     <= 1'b0;
      overflow_pulse <= 1'b0;
      beat_slip      <= 1'b0;
    end
  end

  // NOTE: the slot arrays are plain flops rather than a RAM, so they take the
  // async reset and come up cleared like the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        dir_q[i] <= '0;
        y_q[i]   <= '0;
      end
    end else if (enable) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit_vec[i] || exit_vec[i]) begin
          active_q[i] <= 1'b0;
          y_q[i]      <= '0;
        end else if (active_q[i]) begin
          y_q[i] <= y_inc[i][Y_W-1:0];
        end else if (do_alloc && free_found && (free_idx == SLOT_IDX_W'(i))) begin
          active_q[i] <= 1'b1;
          y_q[i]      <= Y_W'(SPAWN_Y);
          dir_q[i]    <= lat_dir_q;
        end
      end
    end
  end

  assign slot_active = active_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign slot_dir[2*g +: 2]   = dir_q[g];
    assign slot_y[Y_W*g +: Y_W] = y_q[g];
  end

endmodule

// File: tb/tb_arrow_scheduler.sv
// Scoreboard bench for arrow_scheduler: two instances (short and long exit
// distance) share randomized stimulus and are checked against a slot model.
module tb_arrow_scheduler;

  localparam int NS    = 20;
  localparam int YW    = 10;
  localparam int BT    = 4;
  localparam int ST    = 2;
  localparam int SY    = 0;
  localparam int EXIT0 = 10;
  localparam int EXIT1 = 1000;

  typedef struct packed {
    logic [NS-1:0]    act;
    logic [2*NS-1:0]  dir;
    logic [YW*NS-1:0] y;
    logic             ready;
    logic             spawn;
    logic             miss;
    logic             ovf;
    logic             slip;
  } exp_t;

  logic clk, rst, enable, pat_valid, pat_rest, hit_valid;
  logic [1:0] pat_dir;
  logic [4:0] hit_slot;

  logic             ready0, spawn0, miss0, ovf0, slip0;
  logic [NS-1:0]    act0;
  logic [2*NS-1:0]  dir0;
  logic [YW*NS-1:0] y0;
  logic             ready1, spawn1, miss1, ovf1, slip1;
  logic [NS-1:0]    act1;
  logic [2*NS-1:0]  dir1;
  logic [YW*NS-1:0] y1;

  arrow_scheduler #(.NUM_SLOTS(NS), .Y_W(YW), .BEAT_TICKS(BT), .STEP(ST),
                    .SPAWN_Y(SY), .EXIT_Y(EXIT0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .pat_valid(pat_valid),
    .pat_rest(pat_rest), .pat_dir(pat_dir), .pat_ready(ready0),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .slot_active(act0),
    .slot_dir(dir0), .slot_y(y0), .spawn_pulse(spawn0), .miss_pulse(miss0),
    .overflow_pulse(ovf0), .beat_slip(slip0)
  );

  arrow_scheduler #(.NUM_SLOTS(NS), .Y_W(YW), .BEAT_TICKS(BT), .STEP(ST),
                    .SPAWN_Y(SY), .EXIT_Y(EXIT1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .pat_valid(pat_valid),
    .pat_rest(pat_rest), .pat_dir(pat_dir), .pat_ready(ready1),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .slot_active(act1),
    .slot_dir(dir1), .slot_y(y1), .spawn_pulse(spawn1), .miss_pulse(miss1),
    .overflow_pulse(ovf1), .beat_slip(slip1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t q0[$], q1[$];

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting for beat, 2 fetching, 3 allocating.
  int m_phase[2], m_beat[2], m_ldir[2];
  bit m_ready[2], m_rest[2], m_spawn[2], m_miss[2], m_ovf[2], m_slip[2];
  bit m_act[2][NS];
  int m_y[2][NS], m_dir[2][NS];

  function automatic int exit_of(int k);
    return (k == 0) ? EXIT0 : EXIT1;
  endfunction

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_beat[k] = 0; m_ldir[k] = 0; m_ready[k] = 0; m_rest[k] = 0;
    m_spawn[k] = 0; m_miss[k] = 0; m_ovf[k] = 0; m_slip[k] = 0;
    for (int i = 0; i < NS; i++) begin
      m_act[k][i] = 0; m_y[k][i] = 0; m_dir[k][i] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit tc, took;
    bit was[NS];
    int f;
    m_spawn[k] = 0; m_miss[k] = 0; m_ovf[k] = 0; m_slip[k] = 0;
    if (!enable) begin
      m_ready[k] = 0;
      return;
    end
    tc   = (m_beat[k] == BT - 1);
    took = (m_phase[k] == 2) && m_ready[k] && pat_valid;
    for (int i = 0; i < NS; i++) was[i] = m_act[k][i];
    for (int i = 0; i < NS; i++) begin
      if (was[i]) begin
        if (hit_valid && int'(hit_slot) == i) begin
          m_act[k][i] = 0; m_y[k][i] = 0;
        end else if (m_y[k][i] + ST >= exit_of(k)) begin
          m_act[k][i] = 0; m_y[k][i] = 0; m_miss[k] = 1;
        end else begin
          m_y[k][i] = m_y[k][i] + ST;
        end
      end
    end
    if (m_phase[k] == 3 && !m_rest[k]) begin
      f = -1;
      for (int i = 0; i < NS; i++) if (!was[i] && f < 0) f = i;
      if (f >= 0) begin
        m_act[k][f] = 1; m_y[k][f] = SY; m_dir[k][f] = m_ldir[k]; m_spawn[k] = 1;
      end else begin
        m_ovf[k] = 1;
      end
    end
    m_slip[k] = (m_phase[k] == 2) && tc && !took;
    if (took) begin
      m_rest[k] = pat_rest; m_ldir[k] = int'(pat_dir);
    end
    case (m_phase[k])
      0: m_phase[k] = 1;
      1: if (tc) m_phase[k] = 2;
      2: if (took) m_phase[k] = 3;
      default: m_phase[k] = 1;
    endcase
    m_beat[k]  = tc ? 0 : m_beat[k] + 1;
    m_ready[k] = (m_phase[k] == 2);
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    e = '0;
    for (int i = 0; i < NS; i++) begin
      e.act[i]        = m_act[k][i];
      e.dir[2*i +: 2] = 2'(m_dir[k][i]);
      e.y[YW*i +: YW] = YW'(m_y[k][i]);
    end
    e.ready = m_ready[k]; e.spawn = m_spawn[k]; e.miss = m_miss[k];
    e.ovf = m_ovf[k]; e.slip = m_slip[k];
    return e;
  endfunction

  function automatic exp_t dut_out(input int k);
    exp_t a;
    if (k == 0) a = {act0, dir0, y0, ready0, spawn0, miss0, ovf0, slip0};
    else        a = {act1, dir1, y1, ready1, spawn1, miss1, ovf1, slip1};
    return a;
  endfunction

  task automatic compare(input int k, input exp_t e, input exp_t a);
    string p;
    p = $sformatf("d%0d_", k);
    // Direction of a freed slot is a don't-care; compare it only where active.
    for (int i = 0; i < NS; i++) begin
      if (!e.act[i]) begin
        e.dir[2*i +: 2] = 2'b00;
        a.dir[2*i +: 2] = 2'b00;
      end
    end
    check({p, "slot_active"}, 200'(a.act), 200'(e.act));
    check({p, "slot_dir"},    200'(a.dir), 200'(e.dir));
    check({p, "slot_y"},      a.y,         e.y);
    check({p, "pat_ready"},   200'(a.ready), 200'(e.ready));
    check({p, "spawn"},       200'(a.spawn), 200'(e.spawn));
    check({p, "miss"},        200'(a.miss),  200'(e.miss));
    check({p, "overflow"},    200'(a.ovf),   200'(e.ovf));
    check({p, "beat_slip"},   200'(a.slip),  200'(e.slip));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q0.size() > 0) compare(0, q0.pop_front(), dut_out(0));
      if (q1.size() > 0) compare(1, q1.pop_front(), dut_out(1));
    end
  end

  task automatic drive(input bit r, input bit e, input bit pv, input bit prs,
                       input logic [1:0] pd, input bit hv, input logic [4:0] hs);
    @(negedge clk);
    rst = r; enable = e; pat_valid = pv; pat_rest = prs; pat_dir = pd;
    hit_valid = hv; hit_slot = hs;
    for (int k = 0; k < 2; k++) begin
      if (!r) model_reset(k);
      else    model_step(k);
    end
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  // Aim hits at live short-lane arrows, favouring ones about to exit.
  function automatic logic [4:0] pick_hit();
    int cand[$], exits[$];
    for (int i = 0; i < NS; i++) begin
      if (m_act[0][i]) begin
        cand.push_back(i);
        if (m_y[0][i] + ST >= EXIT0) exits.push_back(i);
      end
    end
    if (exits.size() > 0 && $urandom_range(1, 0) == 1)
      return 5'(exits[$urandom_range(exits.size() - 1, 0)]);
    if (cand.size() > 0 && $urandom_range(3, 0) != 0)
      return 5'(cand[$urandom_range(cand.size() - 1, 0)]);
    return 5'($urandom_range(31, 0));
  endfunction

  task automatic random_cycles(input int n);
    bit hv;
    for (int c = 0; c < n; c++) begin
      hv = ($urandom_range(9, 0) < 4);
      drive(1'b1, $urandom_range(9, 0) != 0, $urandom_range(9, 0) < 7,
            $urandom_range(4, 0) == 0, 2'($urandom_range(3, 0)), hv, pick_hit());
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; pat_valid = 1'b0; pat_rest = 1'b0;
    pat_dir = 2'd0; hit_valid = 1'b0; hit_slot = 5'd0;
    model_reset(0);
    model_reset(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd0);

    // Steady pattern, no hits: long lane fills all slots and overflows.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd0);
    for (int c = 0; c < 99; c++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, 2'($urandom_range(3, 0)), 1'b0, 5'd0);
    check("fill_all_slots", 200'(act1), 200'(20'hfffff));

    // Starve the pattern across several beats, pause in FETCH, then resume.
    for (int c = 0; c < 12; c++) drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 5'd25);
    for (int c = 0; c < 4; c++)  drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 5'd0);
    for (int c = 0; c < 6; c++)  drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 5'd25);

    random_cycles(1500);

    // Asynchronous reset mid-run clears outputs without waiting for an edge.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0);
    #1;
    check("rst_async_active", 200'(act0), 200'(0));
    check("rst_async_y",      y0,         200'(0));
    check("rst_async_ready",  200'(ready1), 200'(0));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0);
    random_cycles(300);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 200'(q0.size() + q1.size()), 200'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
